// File: rtl/sha1_msg_sched.sv
// SHA-1 message schedule: loads 16 block words, then issues W0..W79 one per
// handshake, keeping an external round counter in lockstep via cnt_en and
// flagging any disagreement between that counter and the internal index.
module sha1_msg_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        w_valid,
   output logic [31:0] w_data,
   output logic [6:0]  w_idx,
   output logic        w_last,
   input  logic        w_ready,
   output logic        cnt_en,
   input  logic [6:0]  cnt_val,
   output logic        done,
   output logic        sync_err
);

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state;
   logic [3:0]  lcnt;
   logic [6:0]  t;
   logic        done_q;
   logic        sync_q;
   logic [31:0] wbuf [16];

   logic        run;
   logic        load_acc;
   logic        xfer;
   logic [3:0]  t4;
   logic [31:0] mix;
   logic [31:0] w_next;

   assign run      = (state == ST_RUN);
   assign load_acc = in_valid & ~run;
   assign xfer     = run & w_ready;
   assign t4       = t[3:0];

   assign in_ready = ~run;
   assign w_valid  = run;
   assign w_idx    = t;
   assign w_last   = run & (t == 7'd79);
   assign cnt_en   = xfer;
   assign done     = done_q;
   assign sync_err = sync_q;
   assign w_data   = run ? w_next : '0;

   // Schedule word: raw block word for the first 16 rounds, then the
   // recurrence over the circular buffer (wbuf[t4] still holds W(t-16)).
   always_comb begin
      mix    = wbuf[t4 - 4'd3] ^ wbuf[t4 - 4'd8] ^ wbuf[t4 - 4'd14] ^ wbuf[t4];
      w_next = wbuf[t4];
      if (t >= 7'd16) begin
         w_next = {mix[30:0], mix[31]};
      end
   end

   // Control state: load counting, round index, done pulse and sticky sync flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_LOAD;
         lcnt   <= '0;
         t      <= '0;
         done_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!run) begin
            if (in_valid) begin
               // lcnt wraps 15 -> 0 on its own, ready for the next block
               lcnt <= lcnt + 4'd1;
               if (lcnt == 4'd15) begin
                  state <= ST_RUN;
                  t     <= '0;
               end
            end
         end else if (w_ready) begin
            if (cnt_val != t) begin
               sync_q <= 1'b1;
            end
            if (t == 7'd79) begin
               state  <= ST_LOAD;
               t      <= '0;
               done_q <= 1'b1;
            end else begin
               t <= t + 7'd1;
            end
         end
      end
   end

   // Buffer writes: block words during load, computed words from round 16 on.
   always_ff @(posedge clk) begin
      if (load_acc) begin
         wbuf[lcnt] <= in_data;
      end else if (xfer && (t >= 7'd16)) begin
         wbuf[t4] <= w_next;
      end
   end

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Self-checking bench for sha1_msg_sched: a reference schedule model fills a
// scoreboard queue per block, and a negedge monitor pops it on every transfer.
module tb_sha1_msg_sched;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        w_valid;
   logic [31:0] w_data;
   logic [6:0]  w_idx;
   logic        w_last;
   logic        w_ready;
   logic        cnt_en;
   logic [6:0]  cnt_val;
   logic        done;
   logic        sync_err;

   sha1_msg_sched dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .w_valid  (w_valid),
      .w_data   (w_data),
      .w_idx    (w_idx),
      .w_last   (w_last),
      .w_ready  (w_ready),
      .cnt_en   (cnt_en),
      .cnt_val  (cnt_val),
      .done     (done),
      .sync_err (sync_err)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          dn_cnt = 0;
   int          start_cyc = 0;
   int          done_cyc = 0;
   bit          bp = 1'b0;
   bit          gap = 1'b0;
   bit          inject = 1'b0;
   logic [6:0]  ctr = '0;
   logic [38:0] sbq [$];
   logic [31:0] blk [16];
   logic [31:0] exp_w [80];
   logic [31:0] obs [80];
   logic [31:0] ref_obs [80];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Back-pressure source
   initial begin
      w_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         w_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // External 0..79 round counter enabled by cnt_en
   initial begin
      logic en_s;
      forever begin
         @(negedge clk);
         en_s = cnt_en;
         @(posedge clk);
         #1;
         if (!rst_n) ctr = '0;
         else if (en_s) ctr = (ctr == 7'd79) ? 7'd0 : ctr + 7'd1;
      end
   end

   assign cnt_val = ctr + {6'd0, (inject && (w_idx == 7'd40))};

   // Output monitor
   initial begin
      logic        pv, pr;
      logic [31:0] pd;
      logic [6:0]  pi;
      logic [38:0] e;
      pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            check("in_ready", in_ready, !w_valid);
            check("w_last", w_last, (w_valid && (w_idx == 7'd79)));
            check("cnt_en", cnt_en, (w_valid && w_ready));
            if (pv && !pr && w_valid) begin
               check("stall_data", w_data, pd);
               check("stall_idx", w_idx, pi);
            end
            if (w_valid && w_ready) begin
               obs[w_idx] = w_data;
               if (sbq.size() == 0) begin
                  check("sb_empty", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  check("w_data", w_data, e[31:0]);
                  check("w_idx", w_idx, e[38:32]);
               end
            end
            if (done) dn_cnt++;
            pv = w_valid; pr = w_ready; pd = w_data; pi = w_idx;
         end
      end
   end

   function automatic logic [31:0] rotl1(input logic [31:0] x);
      return {x[30:0], x[31]};
   endfunction

   task automatic push_expected();
      for (int i = 0; i < 80; i++) begin
         if (i < 16) exp_w[i] = blk[i];
         else exp_w[i] = rotl1(exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16]);
         sbq.push_back({i[6:0], exp_w[i]});
      end
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", done, 1);
      done_cyc = cyc;
      check("ctr_at_done", ctr, 0);
   endtask

   // Inputs are driven at negedge; acceptance happens on the following posedge.
   task automatic run_block(input bit wait_end);
      int k;
      push_expected();
      for (int i = 0; i < 16; i++) begin
         if (gap && i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
         in_valid = 1'b1;
         in_data  = blk[i];
         k = 0;
         while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (k >= 300) check("load_timeout", 1, 0);
         if (i == 0) start_cyc = cyc;
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = '0;
         if (i < 15) check("load_no_valid", w_valid, 0);
      end
      check("run_entry_valid", w_valid, 1);
      check("run_entry_idx", w_idx, 0);
      if (wait_end) wait_done();
   endtask

   task automatic wait_xfer_idx(input int idx);
      int k;
      k = 0;
      while (!(w_valid && w_ready && (w_idx == idx[6:0])) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("xfer_idx_seen", (k < 300), 1);
   endtask

   initial begin
      int d0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_w_valid", w_valid, 0);
      check("rst_w_last", w_last, 0);
      check("rst_cnt_en", cnt_en, 0);
      check("rst_done", done, 0);
      check("rst_sync_err", sync_err, 0);
      check("rst_w_data", w_data, 0);
      check("rst_w_idx", w_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // "abc" block, no stalls
      set_abc();
      d0 = dn_cnt;
      run_block(1'b1);
      check("period", done_cyc - start_cyc, 96);
      check("W0", obs[0], 32'h61626380);
      check("W15", obs[15], 32'h00000018);
      check("W16", obs[16], 32'hC2C4C700);
      check("W17", obs[17], 32'h00000000);
      check("W18", obs[18], 32'h00000030);
      check("W19", obs[19], 32'h85898E01);
      check("W79", obs[79], exp_w[79]);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("done_count", dn_cnt - d0, 1);
      for (int i = 0; i < 80; i++) ref_obs[i] = obs[i];

      // Same block with back-pressure
      bp = 1'b1;
      run_block(1'b1);
      bp = 1'b0;
      for (int i = 0; i < 80; i++) check("bp_same_seq", obs[i], ref_obs[i]);

      // Three back-to-back blocks, gapped loading, lockstep counter
      gap = 1'b1;
      for (int b = 0; b < 3; b++) begin
         set_rand();
         run_block(1'b1);
      end
      gap = 1'b0;
      check("lockstep_sync", sync_err, 0);

      // in_valid held high through RUN into the next block
      d0 = dn_cnt;
      set_rand();
      run_block(1'b0);
      set_abc();
      run_block(1'b1);
      @(negedge clk);
      check("hold_done_count", dn_cnt - d0, 2);

      // Forced counter mismatch at round 40
      inject = 1'b1;
      set_rand();
      run_block(1'b0);
      wait_xfer_idx(40);
      check("sync_before", sync_err, 0);
      @(negedge clk);
      check("sync_after", sync_err, 1);
      wait_done();
      inject = 1'b0;
      set_rand();
      run_block(1'b1);
      check("sync_sticky", sync_err, 1);

      // Reset mid-RUN at round 37
      set_abc();
      run_block(1'b0);
      wait_xfer_idx(37);
      rst_n = 1'b0;
      sbq.delete();
      d0 = dn_cnt;
      #1;
      check("mid_rst_w_valid", w_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_w_idx", w_idx, 0);
      check("mid_rst_sync", sync_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_rst_no_done", dn_cnt - d0, 0);
      run_block(1'b1);
      check("rst_W79", obs[79], exp_w[79]);
      repeat (2) @(negedge clk);

      check("sb_left", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
